display_scan_digits: RTL

Parametrised multiplexed seven-segment driver for the board top levels: one shared segment bus, one select line per digit, scanned in time. It extends per-digit static decoding with:
- generic digit count and output polarity
- tear-free number updates through a load handshake
- leading-zero blanking, per-digit dots and per-digit blinking

It sits between the design's number source and the board's segment and digit pins.

---
 rtl/display_scan_digits.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/display_scan_digits.sv
// Multiplexed seven-segment scanner: one shared segment bus, one select per digit.
// Number updates are staged in a shadow set and only committed at frame boundaries.
module display_scan_digits #(
  parameter int n_digits       = 6,
  parameter int scan_div       = 50000,
  parameter int blink_div      = 12500000,
  parameter bit seg_active_low = 1'b1,
  parameter bit dig_active_low = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*n_digits-1:0]   number,
  input  logic [n_digits-1:0]     dots,
  input  logic [n_digits-1:0]     blink,
  input  logic                    lz_blank,
  output logic [7:0]              abcdefgh,
  output logic [n_digits-1:0]     digit,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam int CW = (scan_div > 1) ? $clog2(scan_div) : 1;
  localparam int IW = (n_digits > 1) ? $clog2(n_digits) : 1;
  localparam int BW = (blink_div > 1) ? $clog2(blink_div) : 1;
  localparam logic [CW-1:0] cnt_last  = CW'(scan_div - 1);
  localparam logic [IW-1:0] idx_last  = IW'(n_digits - 1);
  localparam logic [BW-1:0] bcnt_last = BW'(blink_div - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           bcnt;
  logic                    phase;
  logic [4*n_digits-1:0]   sh_number, dp_number;
  logic [n_digits-1:0]     sh_dots, dp_dots, sh_blink, dp_blink;
  logic                    sh_lz, dp_lz;

  logic                    slot_end, boundary;
  logic [3:0]              cur_nib;
  logic                    cur_dot, cur_blink, cur_blank, all_zero;
  logic [6:0]              shape;
  logic [7:0]              seg_on;
  logic [n_digits-1:0]     dig_on;

  assign slot_end = (cnt == cnt_last);
  assign boundary = slot_end && (idx == idx_last);

  // Walk from the most significant digit down so all_zero covers digit i and everything above it.
  always_comb begin
    cur_nib   = 4'd0;
    cur_dot   = 1'b0;
    cur_blink = 1'b0;
    cur_blank = 1'b0;
    all_zero  = 1'b1;
    for (int i = n_digits - 1; i >= 0; i--) begin
      all_zero = all_zero && (dp_number[4*i +: 4] == 4'd0);
      if (int'(idx) == i) begin
        cur_nib   = dp_number[4*i +: 4];
        cur_dot   = dp_dots[i];
        cur_blink = dp_blink[i];
        cur_blank = dp_lz && (i != 0) && all_zero;
      end
    end
  end

  // Shapes as a..g, active-high.
  always_comb begin
    shape = 7'b0000000;
    case (cur_nib)
      4'h0: shape = 7'b1111110;
      4'h1: shape = 7'b0110000;
      4'h2: shape = 7'b1101101;
      4'h3: shape = 7'b1111001;
      4'h4: shape = 7'b0110011;
      4'h5: shape = 7'b1011011;
      4'h6: shape = 7'b1011111;
      4'h7: shape = 7'b1110000;
      4'h8: shape = 7'b1111111;
      4'h9: shape = 7'b1111011;
      4'hA: shape = 7'b1110111;
      4'hB: shape = 7'b0011111;
      4'hC: shape = 7'b1001110;
      4'hD: shape = 7'b0111101;
      4'hE: shape = 7'b1001111;
      4'hF: shape = 7'b1000111;
      default: shape = 7'b0000000;
    endcase
  end

  assign seg_on = (cur_blink && phase) ? 8'h00 : {(cur_blank ? 7'b0000000 : shape), cur_dot};
  assign dig_on = (cnt == '0) ? '0 : (n_digits'(1) << idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      bcnt       <= '0;
      phase      <= 1'b0;
      sh_number  <= '0;
      sh_dots    <= '0;
      sh_blink   <= '0;
      sh_lz      <= 1'b0;
      dp_number  <= '0;
      dp_dots    <= '0;
      dp_blink   <= '0;
      dp_lz      <= 1'b0;
      pending    <= 1'b0;
      digit      <= {n_digits{dig_active_low}};
      abcdefgh   <= {8{seg_active_low}};
      frame_tick <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= (idx == idx_last) ? '0 : idx + 1'b1;

      if (bcnt == bcnt_last) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end

      if (load) begin
        sh_number <= number;
        sh_dots   <= dots;
        sh_blink  <= blink;
        sh_lz     <= lz_blank;
      end

      // A load on the boundary itself bypasses the shadow and never raises pending.
      if (boundary) begin
        if (load) begin
          dp_number <= number;
          dp_dots   <= dots;
          dp_blink  <= blink;
          dp_lz     <= lz_blank;
        end else if (pending) begin
          dp_number <= sh_number;
          dp_dots   <= sh_dots;
          dp_blink  <= sh_blink;
          dp_lz     <= sh_lz;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end

      digit      <= dig_on ^ {n_digits{dig_active_low}};
      abcdefgh   <= seg_on ^ {8{seg_active_low}};
      frame_tick <= boundary;
    end
  end

endmodule
